mem_arbiter: RTL

Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the MIPS datapath. It is a registered grant FSM with data priority and a starvation guard for fetch. RAM control is driven from the current grant, and each requester is stalled with a per-side wait signal. It sits between the datapath's fetch/memory stages and the RAM model, and replaces direct RAM wiring.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared MIPS memory-side types: word, RAM handshake state, arbiter grant state,
// plus the grant-selection rule used by the arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DGNT  = 2'd1,
    IGNT  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // Data wins unless fetch has been starved for the configured number of grants.
  function automatic arb_state_t pick_grant(input logic dreq, input logic ireq,
                                            input logic starved);
    if (dreq && !starved) return DGNT;
    if (ireq) return IGNT;
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch/data with data priority and a fetch starvation guard; MEM_TIMEOUT_EN adds a busy watchdog.
// Grant one cycle after a request is seen idle; requesters are held by iwait/dwait until the RAM reports ACCESS/ERROR.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      mem_err
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("mem_arbiter: parameter out of range");
  end

  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       dreq, ram_done, d_done, i_done;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_q, tmo_d;
  logic       abort_dside_q, abort_dside_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
`ifdef MEM_TIMEOUT_EN
      tmo_q         <= 8'd0;
      abort_dside_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q         <= tmo_d;
      abort_dside_q <= abort_dside_d;
`endif
    end
  end

  assign dreq     = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);
  assign d_done   = (state_q == DGNT) && ram_done;
  assign i_done   = (state_q == IGNT) && ram_done;

  always_comb begin
    state_d = state_q;
    if (!iREN || i_done) starve_d = 4'd0;
    else if (d_done && starve_q < STARVE_MAX) starve_d = starve_q + 4'd1;
    else starve_d = starve_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d         = ((state_q == DGNT || state_q == IGNT) && !ram_done) ? tmo_q + 8'd1 : 8'd0;
    abort_dside_d = (state_q == DGNT);
`endif
    // The choice on completion uses the post-update starvation count, so the
    // STARVE_LIMIT-th data completion hands the port to fetch.
    case (state_q)
      IDLE: state_d = pick_grant(dreq, iREN, starve_d >= STARVE_MAX);
      DGNT: begin
        if (d_done) state_d = pick_grant(dreq, iREN, starve_d >= STARVE_MAX);
        else if (!dreq) state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (tmo_d == TMO_LAST) state_d = ABORT;
`endif
      end
      IGNT: begin
        if (i_done) state_d = pick_grant(dreq, iREN, starve_d >= STARVE_MAX);
        else if (!iREN) state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (tmo_d == TMO_LAST) state_d = ABORT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state_q)
      DGNT: begin
        ramaddr  = daddr;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dstore;
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
    if (d_done) dload = ramload;
    if (i_done) iload = ramload;
    mem_err = (d_done || i_done) && (ramstate == ERROR);
    iwait   = iREN & ~i_done;
    dwait   = dreq & ~d_done;
`ifdef MEM_TIMEOUT_EN
    if (state_q == ABORT) begin
      mem_err = 1'b1;
      if (abort_dside_q) dwait = 1'b0;
      else iwait = 1'b0;
    end
`endif
  end

endmodule
